// File: rtl/lane_unloader_if.sv
// Lane write port and streaming output handshake between the lane
// unloader and its producer/consumer.
interface lane_unloader_if #(
  parameter int unsigned W  = 64,
  parameter int unsigned IW = 5
);
  logic          wrEn;
  logic [IW-1:0] wrIdx;
  logic [W-1:0]  wrData;
  logic          start;
  logic          outReady;
  logic          outValid;
  logic [W-1:0]  outData;
  logic [IW-1:0] outIdx;
  logic          busy;
  logic          done;

  modport master (
    output wrEn, wrIdx, wrData, start, outReady,
    input  outValid, outData, outIdx, busy, done
  );

  modport slave (
    input  wrEn, wrIdx, wrData, start, outReady,
    output outValid, outData, outIdx, busy, done
  );
endinterface

// File: rtl/lane_unloader.sv
// 25 x 64-bit lane buffer: random-access writes while idle, then streams
// lanes 0..24 in order over a valid/ready handshake.
module lane_unloader (
  input  logic           clk,
  input  logic           rst,
  lane_unloader_if.slave bus
);
  localparam int unsigned LANES = 25;
  localparam int unsigned W     = 64;
  localparam int unsigned IW    = 5;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t        state, state_d;
  logic [IW-1:0] cnt, cnt_d;
  logic [W-1:0]  data_q, data_d;
  logic          done_q, done_d;
  logic [W-1:0]  mem [LANES];
  logic          wr_ok_c;
  logic [IW-1:0] cnt_nxt_c;

  assign wr_ok_c   = bus.wrEn && (bus.wrIdx < IW'(LANES)) && (state == IDLE);
  assign cnt_nxt_c = cnt + IW'(1);

  // Lane storage is never cleared; it is frozen while a stream is in flight.
  always_ff @(posedge clk) begin
    if (wr_ok_c) mem[bus.wrIdx] <= bus.wrData;
  end

  // Next-state and next-output logic; outData is registered, so lane 0 is
  // bypassed from the write port when it is written in the start cycle.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    data_d  = data_q;
    done_d  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_d = STREAM;
          cnt_d   = '0;
          data_d  = (wr_ok_c && (bus.wrIdx == '0)) ? bus.wrData : mem[0];
        end
      end
      STREAM: begin
        if (bus.outReady) begin
          if (cnt == IW'(LANES - 1)) begin
            state_d = IDLE;
            cnt_d   = '0;
            data_d  = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d  = cnt_nxt_c;
            data_d = mem[cnt_nxt_c];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      data_q <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      data_q <= data_d;
      done_q <= done_d;
    end
  end

  assign bus.outValid = (state == STREAM);
  assign bus.busy     = (state == STREAM);
  assign bus.outIdx   = cnt;
  assign bus.outData  = data_q;
  assign bus.done     = done_q;
endmodule

// File: doc/lane_unloader.md
# lane_unloader

Read-side companion to the lane memory that the datapath fills. It holds a 25-lane × 64-bit state buffer, accepts random-access lane writes while idle, and on `start` streams the lanes out in linear order. Lane `n` is sent for n = x + 5·y, 0..24, over a valid/ready handshake. It is the output end of the state pipeline and feeds a downstream consumer, such as a file writer or the next round stage, one lane per accepted transfer.

## Interface
- `LANES`, 25, number of lanes held and streamed.
- `W`, 64, lane width in bits.
- `IW`, 5, lane index width.

- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-low reset, sampled on `clk` rising edge.
- `wrEn`  in  1  lane write strobe.
- `wrIdx`  in  IW  lane index to write, 0..LANES-1.
- `wrData`  in  W  lane value to write.
- `start`  in  1  single-cycle request to begin streaming.
- `outReady`  in  1  consumer can accept the current lane.
- `outValid`  out  1  `outData`/`outIdx` hold a valid lane.
- `outData`  out  W  lane value.
- `outIdx`  out  IW  index of the lane on `outData`.
- `busy`  out  1  high while streaming.
- `done`  out  1  one-cycle pulse after the last lane is accepted.

## Operation
- States: IDLE, STREAM.
- **IDLE**
  - `wrEn` with `wrIdx` < LANES writes `mem[wrIdx] <= wrData`.
  - `wrIdx` ≥ LANES is ignored.
  - `start` sets the counter to 0 and moves to STREAM.
- **STREAM**
  - `outValid` = 1, `outIdx` = counter, `outData` = `mem[counter]`.
  - A transfer occurs on a cycle with `outValid` & `outReady`.
  - On a transfer with counter < LANES-1: counter increments.
  - On a transfer with counter = LANES-1: go to IDLE and assert `done` for the next cycle only.
- Writes during STREAM are ignored; memory is frozen for the stream.
- `start` during STREAM is ignored.
- `start` and `wrEn` in the same IDLE cycle: the write is performed, the stream starts, and the streamed data includes that write. If `wrIdx` = 0, lane 0 must show the new `wrData`, so bypass if `outData` is registered.
- With `outReady` low, `outData`/`outIdx` hold stable and `outValid` stays 1. No lane is skipped or repeated.
- Counter is IW bits wide and never exceeds LANES-1; there is no wrap-around within a stream.
- `busy` = (state == STREAM).

## Timing
- Reset (`rst` = 0 at an edge): state IDLE, counter 0, `outValid` 0, `outData` 0, `outIdx` 0, `busy` 0, `done` 0. Memory contents are not cleared.
- Reset mid-stream aborts immediately: the next cycle shows all outputs at reset values, no `done` pulse, and no further lanes.
- `start` sampled at edge t: `outValid`/`busy` are high from t+1, with lane 0 presented at t+1.
- With `outReady` held high, lane k is presented in cycle t+1+k. `outValid` falls and `done` = 1 in cycle t+26. `busy` is low in t+26. Throughput is 1 lane/cycle.
- Each cycle of `outReady` low adds exactly one cycle to the stream.
- Write latency: a lane written at edge t is readable by a stream started at edge ≥ t.
- A new `start` is accepted in the same cycle `done` is high. The next stream then begins one cycle later.

## Test plan
- Fill lanes n = 0..24 with `64'h0101010101010101 * n`, then `start` with `outReady` = 1. Required: 25 consecutive valid cycles, `outIdx` 0..24 in order, each `outData` matching its lane, and `done` high only in cycle t+26.
- Backpressure: `outReady` toggles 1,0,0,1,… across the stream. Required: every lane appears exactly once in order, data is stable while stalled, and `done` is delayed by the number of stall cycles.
- Write `wrIdx` = 25 and 31 with `64'hDEAD`, then stream. Required: all 25 lanes are unchanged.
- During STREAM, pulse `wrEn` to lane 3 with `64'hFFFF` and pulse `start` again. Required: lane 3 streams its old value, there is a single `done`, and no restart occurs.
- Same-cycle `start` + `wrEn` (`wrIdx` = 0, `64'hA5A5A5A5A5A5A5A5`). Required: the first output is `64'hA5A5A5A5A5A5A5A5` with `outIdx` 0.
- Assert `rst` = 0 while lane 10 is on the outputs. Required: all outputs are 0 next cycle and there is no `done`. A following `start` streams all lanes starting from lane 0 with the previously written data intact.
